// File: rtl/iir_biquad_mc_pkg.sv
// Shared types, coefficient indices and saturation helper for the multichannel biquad.
package iir_biquad_mc_pkg;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StMac  = 2'd1;
  localparam state_t StWb   = 2'd2;

  localparam int unsigned NCOEF = 5;
  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A1 = 3'd3;
  localparam logic [2:0] A2 = 3'd4;

  localparam int unsigned SatW = 64;

  // Clamp v to the signed range of an ow-bit value.
  function automatic logic signed [SatW-1:0] saturate(input logic signed [SatW-1:0] v,
                                                      input int unsigned ow);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// Shared multiplier with rounding accumulator, arithmetic shift and output saturation.
module iir_mac_sat
  import iir_biquad_mc_pkg::*;
#(
  parameter int unsigned MW   = 11,
  parameter int unsigned CW   = 16,
  parameter int unsigned AW   = 31,
  parameter int unsigned FRAC = 10,
  parameter int unsigned OW   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 en,
  input  logic signed [MW-1:0] operand,
  input  logic signed [CW-1:0] coef,
  output logic signed [OW-1:0] y,
  output logic                 sat
);

  localparam logic signed [AW-1:0] Rnd = {{(AW - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

  logic signed [AW-1:0]    acc_q;
  logic signed [MW+CW-1:0] prod;
  logic signed [SatW-1:0]  wide;
  logic signed [SatW-1:0]  sat_v;

  assign prod = operand * coef;

  // Rounding constant is preloaded so the five products land on a pre-biased sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (start) begin
      acc_q <= Rnd;
    end else if (en) begin
      acc_q <= acc_q + AW'(prod);
    end
  end

  always_comb begin
    wide  = SatW'(acc_q >>> FRAC);
    sat_v = saturate(wide, OW);
    y     = OW'(sat_v);
    sat   = (sat_v != wide);
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed direct-form-I biquad: one shared MAC, 7 cycles per sample, NCH channels.
module iir_biquad_mc
  import iir_biquad_mc_pkg::*;
#(
  parameter int unsigned DW   = 9,
  parameter int unsigned OW   = 11,
  parameter int unsigned CW   = 16,
  parameter int unsigned FRAC = 10,
  parameter int unsigned NCH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NCH)-1:0]   in_ch,
  input  logic signed [DW-1:0]     in_data,
  input  logic                     coef_we,
  input  logic [$clog2(NCH)-1:0]   coef_ch,
  input  logic [2:0]               coef_sel,
  input  logic signed [CW-1:0]     coef_data,
  input  logic [NCH-1:0]           clr_ch,
  output logic                     out_valid,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic signed [OW-1:0]     out_data,
  output logic                     sat_flag,
  input  logic                     sat_clr
);

  localparam int unsigned MW  = (DW > OW) ? DW : OW;
  localparam int unsigned AW  = MW + CW + 4;
  localparam int unsigned CHW = $clog2(NCH);

  state_t               state_q, state_d;
  logic [2:0]           idx_q;
  logic [CHW-1:0]       ch_q;
  logic signed [DW-1:0] x_q;
  logic [NCH-1:0]       clr_pend_q;
  logic signed [CW-1:0] coef_q [NCH][NCOEF];
  logic signed [CW-1:0] snap_q [NCOEF];
  logic signed [DW-1:0] x1_q [NCH];
  logic signed [DW-1:0] x2_q [NCH];
  logic signed [OW-1:0] y1_q [NCH];
  logic signed [OW-1:0] y2_q [NCH];

  logic                 accept;
  logic signed [MW-1:0] operand;
  logic signed [CW-1:0] coef;
  logic signed [OW-1:0] y;
  logic                 sat;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMac;
      StMac:   if (idx_q == A2) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= B0;
      ch_q       <= '0;
      x_q        <= '0;
      clr_pend_q <= '0;
      for (int k = 0; k < NCOEF; k++) snap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= B0;
        ch_q  <= in_ch;
        x_q   <= in_data;
        for (int k = 0; k < NCOEF; k++) snap_q[k] <= coef_q[in_ch][k];
      end else if (state_q == StMac) begin
        idx_q <= idx_q + 3'd1;
      end
      // Clears seen mid-computation are deferred to the write-back cycle.
      if (state_q == StMac) clr_pend_q <= clr_pend_q | clr_ch;
      else                  clr_pend_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NCOEF; k++) coef_q[c][k] <= '0;
    end else if (coef_we) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NCOEF; k++)
          if (coef_ch == CHW'(c) && coef_sel == 3'(k)) coef_q[c][k] <= coef_data;
    end
  end

  always_comb begin
    operand = '0;
    coef    = '0;
    unique case (idx_q)
      B0:      operand = MW'(x_q);
      B1:      operand = MW'(x1_q[ch_q]);
      B2:      operand = MW'(x2_q[ch_q]);
      A1:      operand = MW'(y1_q[ch_q]);
      A2:      operand = MW'(y2_q[ch_q]);
      default: operand = '0;
    endcase
    for (int k = 0; k < NCOEF; k++) if (idx_q == 3'(k)) coef = snap_q[k];
  end

  iir_mac_sat #(
    .MW   (MW),
    .CW   (CW),
    .AW   (AW),
    .FRAC (FRAC),
    .OW   (OW)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .en      (state_q == StMac),
    .operand (operand),
    .coef    (coef),
    .y       (y),
    .sat     (sat)
  );

  // Later assignments win, so a clear overrides the write-back update of the same channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (state_q == StWb && ch_q == CHW'(c)) begin
          x2_q[c] <= x1_q[c];
          x1_q[c] <= x_q;
          y2_q[c] <= y1_q[c];
          y1_q[c] <= y;
        end
        if ((state_q == StIdle && clr_ch[c]) ||
            (state_q == StWb && (clr_ch[c] || clr_pend_q[c]))) begin
          x1_q[c] <= '0;
          x2_q[c] <= '0;
          y1_q[c] <= '0;
          y2_q[c] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= (state_q == StWb);
      if (state_q == StWb) begin
        out_ch   <= ch_q;
        out_data <= y;
      end
      if (state_q == StWb && sat) sat_flag <= 1'b1;
      else if (sat_clr)           sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Randomised and directed bench for iir_biquad_mc against an arithmetic reference model.
module tb_iir_biquad_mc;

  localparam int DW = 9, OW = 11, CW = 16, FRAC = 10, NCH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [1:0]         in_ch = '0;
  logic signed [DW-1:0] in_data = '0;
  logic               coef_we = 1'b0;
  logic [1:0]         coef_ch = '0;
  logic [2:0]         coef_sel = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic [NCH-1:0]     clr_ch = '0;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [OW-1:0] out_data;
  logic               sat_flag;
  logic               sat_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  longint mc [NCH][5];
  longint mx1 [NCH], mx2 [NCH], my1 [NCH], my2 [NCH];
  bit     msat;

  always #5 clk = ~clk;

  iir_biquad_mc #(
    .DW (DW), .OW (OW), .CW (CW), .FRAC (FRAC), .NCH (NCH)
  ) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready), .in_ch (in_ch),
    .in_data (in_data), .coef_we (coef_we), .coef_ch (coef_ch), .coef_sel (coef_sel),
    .coef_data (coef_data), .clr_ch (clr_ch), .out_valid (out_valid), .out_ch (out_ch),
    .out_data (out_data), .sat_flag (sat_flag), .sat_clr (sat_clr)
  );

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 5; k++) mc[c][k] = 0;
      mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
    end
    msat = 0;
  endfunction

  function automatic void model_clear(logic [NCH-1:0] m);
    for (int c = 0; c < NCH; c++)
      if (m[c]) begin mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0; end
  endfunction

  // y = sat((b.x + a.y + 2^(FRAC-1)) >>> FRAC), then shift history.
  function automatic int model_sample(int ch, int x, logic [NCH-1:0] clr_acc,
                                      logic [NCH-1:0] clr_mid);
    longint acc, yv;
    model_clear(clr_acc);
    acc = mc[ch][0] * x + mc[ch][1] * mx1[ch] + mc[ch][2] * mx2[ch]
        + mc[ch][3] * my1[ch] + mc[ch][4] * my2[ch] + (64'sd1 <<< (FRAC - 1));
    yv = acc >>> FRAC;
    if (yv > 1023) begin yv = 1023; msat = 1; end
    else if (yv < -1024) begin yv = -1024; msat = 1; end
    mx2[ch] = mx1[ch]; mx1[ch] = x; my2[ch] = my1[ch]; my1[ch] = yv;
    model_clear(clr_mid);
    return int'(yv);
  endfunction

  task automatic write_coef(input int ch, input int sel, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_ch = 2'(ch); coef_sel = 3'(sel); coef_data = CW'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (sel < 5) mc[ch][sel] = val;
  endtask

  task automatic clear(input logic [NCH-1:0] m);
    @(negedge clk);
    clr_ch = m;
    @(negedge clk);
    clr_ch = '0;
    model_clear(m);
  endtask

  // Offers one sample; returns the cycle (after the accept edge) of the first out_valid.
  task automatic send(input int ch, input int x, input logic [NCH-1:0] clr_acc,
                      input logic [NCH-1:0] clr_mid, input bit cw, input int cw_ch,
                      input int cw_sel, input int cw_val,
                      output int lat, output int och, output int odata);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    in_valid = 1'b1; in_ch = 2'(ch); in_data = DW'(x); clr_ch = clr_acc;
    @(negedge clk);
    in_valid = 1'b0; clr_ch = '0;
    lat = -1; och = -1; odata = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2 && cw) begin
        coef_we = 1'b1; coef_ch = 2'(cw_ch); coef_sel = 3'(cw_sel); coef_data = CW'(cw_val);
      end
      if (k == 3) begin coef_we = 1'b0; clr_ch = clr_mid; end
      if (k == 4) clr_ch = '0;
      @(negedge clk);
      if (out_valid) begin lat = k; och = out_ch; odata = $signed(out_data); break; end
    end
    coef_we = 1'b0; clr_ch = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%0d ch=%0d sat=%b want all 0",
               out_valid, out_data, out_ch, sat_flag);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_passthrough();
    int lat, och, od, e;
    write_coef(0, 0, 1024);
    e = model_sample(0, 100, '0, '0);
    send(0, 100, '0, '0, 0, 0, 0, 0, lat, och, od);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL pass_latency got %0d want 6", lat); end
    checks++;
    if (och !== 0) begin failures++; $display("FAIL pass_ch got %0d want 0", och); end
    checks++;
    if (od !== 100 || e !== 100) begin
      failures++; $display("FAIL pass_data got %0d want 100", od);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || $signed(out_data) !== 100) begin
      failures++;
      $display("FAIL pass_hold got v=%b d=%0d want v=0 d=100", out_valid, $signed(out_data));
    end
  endtask

  task automatic test_impulse();
    int lat, och, od;
    int want [2];
    want[0] = 255; want[1] = 213;
    write_coef(1, 0, 1024); write_coef(1, 1, 52); write_coef(1, 2, 1024);
    write_coef(1, 3, 805); write_coef(1, 4, -743);
    for (int i = 0; i < 2; i++) begin
      void'(model_sample(1, (i == 0) ? 255 : 0, '0, '0));
      send(1, (i == 0) ? 255 : 0, '0, '0, 0, 0, 0, 0, lat, och, od);
      checks++;
      if (od !== want[i] || och !== 1 || lat !== 6) begin
        failures++;
        $display("FAIL impulse_%0d got d=%0d ch=%0d lat=%0d want d=%0d ch=1 lat=6",
                 i, od, och, lat, want[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat, och, od;
    write_coef(2, 0, 32767);
    void'(model_sample(2, 255, '0, '0));
    send(2, 255, '0, '0, 0, 0, 0, 0, lat, och, od);
    checks++;
    if (od !== 1023 || sat_flag !== 1'b1) begin
      failures++; $display("FAIL sat_pos got d=%0d sat=%b want 1023 1", od, sat_flag);
    end
    @(negedge clk); sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0; msat = 0;
    checks++;
    if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_clr got %b want 0", sat_flag); end
    // sat_clr held across a saturating write-back: set must win.
    sat_clr = 1'b1;
    void'(model_sample(2, 255, '0, '0));
    send(2, 255, '0, '0, 0, 0, 0, 0, lat, och, od);
    checks++;
    if (sat_flag !== 1'b1) begin
      failures++; $display("FAIL sat_collide got %b want 1", sat_flag);
    end
    sat_clr = 1'b0;
    void'(model_sample(2, -256, '0, '0));
    send(2, -256, '0, '0, 0, 0, 0, 0, lat, och, od);
    checks++;
    if (od !== -1024) begin failures++; $display("FAIL sat_neg got %0d want -1024", od); end
    @(negedge clk); sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0; msat = 0;
  endtask

  task automatic test_isolation();
    int lat, och, od, e;
    int xs0 [3], xs1 [3], solo0 [3], solo1 [3];
    xs0[0] = 100; xs0[1] = -50; xs0[2] = 30;
    xs1[0] = 255; xs1[1] = 0;   xs1[2] = 0;
    write_coef(0, 1, 512); write_coef(0, 3, -400);
    clear(4'b0011);
    for (int i = 0; i < 3; i++) begin
      void'(model_sample(0, xs0[i], '0, '0));
      send(0, xs0[i], '0, '0, 0, 0, 0, 0, lat, och, solo0[i]);
    end
    for (int i = 0; i < 3; i++) begin
      void'(model_sample(1, xs1[i], '0, '0));
      send(1, xs1[i], '0, '0, 0, 0, 0, 0, lat, och, solo1[i]);
    end
    clear(4'b0011);
    for (int i = 0; i < 3; i++) begin
      e = model_sample(0, xs0[i], '0, '0);
      send(0, xs0[i], '0, '0, 0, 0, 0, 0, lat, och, od);
      checks++;
      if (od !== solo0[i] || od !== e) begin
        failures++; $display("FAIL iso_ch0_%0d got %0d want %0d", i, od, e);
      end
      e = model_sample(1, xs1[i], '0, '0);
      send(1, xs1[i], '0, '0, 0, 0, 0, 0, lat, och, od);
      checks++;
      if (od !== solo1[i] || od !== e) begin
        failures++; $display("FAIL iso_ch1_%0d got %0d want %0d", i, od, e);
      end
    end
    e = model_sample(0, 77, '0, '0);
    send(0, 77, '0, '0, 1, 1, 0, 2000, lat, och, od);
    mc[1][0] = 2000;
    checks++;
    if (od !== e) begin failures++; $display("FAIL iso_cw_ch0 got %0d want %0d", od, e); end
    e = model_sample(1, 5, '0, '0);
    send(1, 5, '0, '0, 0, 0, 0, 0, lat, och, od);
    checks++;
    if (od !== e) begin failures++; $display("FAIL iso_cw_ch1 got %0d want %0d", od, e); end
    write_coef(1, 0, 1024);
  endtask

  task automatic test_clear_collision();
    int lat, och, od, e;
    void'(model_sample(1, 255, '0, '0));
    send(1, 255, '0, '0, 0, 0, 0, 0, lat, och, od);
    e = model_sample(1, 10, 4'b0010, '0);
    send(1, 10, 4'b0010, '0, 0, 0, 0, 0, lat, och, od);
    checks++;
    if (od !== 10 || e !== 10) begin
      failures++; $display("FAIL clr_collide got %0d want 10", od);
    end
  endtask

  task automatic test_random();
    int lat, och, od, e, ch, x;
    logic [NCH-1:0] ca, cm;
    bit cw;
    int cch, csel, cval;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 3; k++) write_coef(c, k, int'($urandom_range(0, 4095)) - 2048);
      write_coef(c, 3, int'($urandom_range(0, 2047)) - 1024);
      write_coef(c, 4, int'($urandom_range(0, 1023)) - 512);
    end
    for (int i = 0; i < 24; i++) begin
      ch = int'($urandom_range(0, NCH - 1));
      x = int'($urandom_range(0, 511)) - 256;
      ca = ($urandom_range(0, 5) == 0) ? NCH'($urandom_range(1, 15)) : '0;
      cm = ($urandom_range(0, 5) == 0) ? NCH'($urandom_range(1, 15)) : '0;
      cw = ($urandom_range(0, 3) == 0);
      cch = ($urandom_range(0, 1) == 0) ? ch : int'($urandom_range(0, NCH - 1));
      csel = int'($urandom_range(0, 7));
      cval = int'($urandom_range(0, 8191)) - 4096;
      e = model_sample(ch, x, ca, cm);
      send(ch, x, ca, cm, cw, cch, csel, cval, lat, och, od);
      if (cw && csel < 5) mc[cch][csel] = cval;
      checks++;
      if (od !== e || och !== ch || lat !== 6) begin
        failures++;
        $display("FAIL rand_%0d got d=%0d ch=%0d lat=%0d want d=%0d ch=%0d lat=6",
                 i, od, och, lat, e, ch);
      end
      checks++;
      if (sat_flag !== msat) begin
        failures++; $display("FAIL rand_sat_%0d got %b want %b", i, sat_flag, msat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int xs [6], chs [6];
    int expq [$], chq [$], accq [$];
    int n_acc, n_out, cyc, last_acc, e, ec, ea;
    bit reload;
    n_acc = 0; n_out = 0; cyc = 0; last_acc = -1; reload = 0;
    for (int i = 0; i < 6; i++) begin
      xs[i] = int'($urandom_range(0, 511)) - 256;
      chs[i] = int'($urandom_range(0, NCH - 1));
    end
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'(chs[0]); in_data = DW'(xs[0]);
    while (n_out < 6 && cyc < 200) begin
      if (out_valid) begin
        e = expq.pop_front(); ec = chq.pop_front(); ea = accq.pop_front();
        checks++;
        if ($signed(out_data) !== e || out_ch !== 2'(ec) || cyc - ea !== 7) begin
          failures++;
          $display("FAIL b2b_out_%0d got d=%0d ch=%0d lat=%0d want d=%0d ch=%0d lat=7",
                   n_out, $signed(out_data), out_ch, cyc - ea, e, ec);
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model_sample(chs[n_acc], xs[n_acc], '0, '0));
        chq.push_back(chs[n_acc]);
        accq.push_back(cyc);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 7) begin
            failures++; $display("FAIL b2b_rate got %0d want 7", cyc - last_acc);
          end
        end
        last_acc = cyc; n_acc++; reload = 1;
      end else if (reload) begin
        reload = 0;
        if (n_acc < 6) begin in_ch = 2'(chs[n_acc]); in_data = DW'(xs[n_acc]); end
        else in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (n_out !== 6) begin failures++; $display("FAIL b2b_timeout got %0d want 6", n_out); end
  endtask

  task automatic test_mid_reset();
    int lat, och, od;
    bit seen;
    void'(model_sample(2, 255, '0, '0));
    send(2, 255, '0, '0, 0, 0, 0, 0, lat, och, od);
    in_valid = 1'b1; in_ch = 2'd0; in_data = 9'sd50;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs got v=%b d=%0d ch=%0d sat=%b want all 0",
               out_valid, out_data, out_ch, sat_flag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (out_valid) seen = 1; end
    checks++;
    if (seen) begin failures++; $display("FAIL midrst_no_out got 1 want 0"); end
    void'(model_sample(0, 100, '0, '0));
    send(0, 100, '0, '0, 0, 0, 0, 0, lat, och, od);
    checks++;
    if (od !== 0 || lat !== 6) begin
      failures++; $display("FAIL midrst_coef_zero got d=%0d lat=%0d want 0 6", od, lat);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_impulse();
    test_saturation();
    test_isolation();
    test_clear_collision();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_biquad_mc.md
IIR_BIQUAD_MC -- requirements
Module: iir_biquad_mc

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- DW, 9, signed input sample width.
- OW, 11, signed output sample width.
- CW, 16, signed coefficient width.
- FRAC, 10, coefficient fractional bits.
- NCH, 4, number of time-multiplexed channels.
REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-high.
- in_valid, in, 1, sample offered.
- in_ready, out, 1, sample accepted when in_valid and in_ready are both high.
- in_ch, in, clog2(NCH), channel of the offered sample.
- in_data, in, DW, signed sample.
- coef_we, in, 1, coefficient write strobe.
- coef_ch, in, clog2(NCH), target channel.
- coef_sel, in, 3, coefficient index: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored.
- coef_data, in, CW, signed coefficient.
- clr_ch, in, NCH, one-hot per-channel history clear, level-sampled.
- out_valid, out, 1, one-cycle result pulse.
- out_ch, out, clog2(NCH), channel of the result.
- out_data, out, OW, signed result.
- sat_flag, out, 1, sticky saturation indicator.
- sat_clr, in, 1, clears sat_flag.

Function
REQ-003 Each channel SHALL compute y[n] = sat_OW((b0·x[n] + b1·x[n-1] + b2·x[n-2] + a1·y[n-1] + a2·y[n-2] + 2^(FRAC-1)) >>> FRAC). The shift SHALL be arithmetic.
REQ-004 The accumulator SHALL be DW+CW+4 bits or wider and SHALL NOT overflow at any operand values.
REQ-005 A single shared signed multiplier SHALL be used. The FSM SHALL have states IDLE, MAC (5 cycles, coefficient index 0..4), WB.
REQ-006 In IDLE, in_ready SHALL be 1; it SHALL be 0 in MAC and WB. A handshake SHALL move IDLE to MAC and latch in_ch and in_data. The last MAC cycle SHALL move to WB; WB SHALL return to IDLE.
REQ-007 out_valid SHALL pulse exactly 6 cycles after the accept edge, with out_ch equal to the accepted channel. out_data SHALL hold its value until the next result.
REQ-008 In WB, the accepted channel's history SHALL update as x2<=x1, x1<=x, y2<=y1, y1<=saturated y.
REQ-009 Saturation SHALL clamp to [-2^(OW-1), 2^(OW-1)-1] and set sat_flag. sat_flag SHALL stay set until sat_clr.
REQ-010 If sat_clr and a saturation event coincide in one cycle, sat_flag SHALL be set.
REQ-011 Coefficient writes SHALL be accepted in any state and take one cycle.
REQ-012 On accept, the five coefficients of the accepted channel SHALL be snapshotted. A coef_we arriving mid-computation SHALL affect only later samples.
REQ-013 A clr_ch bit seen in IDLE SHALL zero that channel's x1, x2, y1, y2. A clr_ch bit seen in MAC or WB SHALL be applied at the WB cycle, after the history update.
REQ-014 If clr_ch and an accept target the same channel in the same IDLE cycle, the clear SHALL win: the sample SHALL compute with zero history.
REQ-015 Channels SHALL be fully independent. Back-to-back accepts SHALL sustain one sample per 7 cycles.

Reset
REQ-016 rst SHALL asynchronously force:
- FSM to IDLE.
- All histories and all coefficients to 0.
- out_valid, out_data, out_ch and sat_flag to 0.
- in_ready to 1 after release.
REQ-017 rst during MAC or WB SHALL abandon the sample. No out_valid SHALL follow that sample.

Structure
REQ-018 A shared package SHALL hold the FSM state enum, the coefficient-index constants (B0..A2) and a saturate function.
REQ-019 Per-channel history and coefficient storage SHALL be register arrays indexed by channel; no RAM macro is required.
REQ-020 One sub-module, iir_mac_sat (multiply-accumulate, round, saturate), is natural and SHALL be used.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, with DW=9, OW=11, CW=16, FRAC=10:
- Passthrough: ch0 b0=1024, other coefficients 0, x=100 -> out_valid at accept+6, out_ch=0, out_data=100.
- Impulse: ch1 b=(1024,52,1024), a1=805, a2=-743; inputs 255 then 0 -> out_data 255, then 213.
- Saturation: ch2 b0=32767, x=255 -> out_data=1023, sat_flag=1. sat_clr -> sat_flag=0.
- Isolation: interleave ch0 and ch1 samples -> each channel's output matches its solo run. A coef_we to ch1 during a ch0 MAC leaves ch0 unchanged.
- Clear collision: clr_ch[1] together with an accept on ch1 carrying x=10 in the impulse configuration -> out_data=10.
- Mid-operation reset: assert rst 3 cycles after accept -> no out_valid; all outputs 0; in_ready=1 after release.
